// File: rtl/rf_wb_sched_if.sv
// Bundle of the write-back scheduler's producer, issue, hazard-check and rf-facing signals.
// The master modport is the pipeline side (producers, decode, rf); the slave modport is the scheduler.
interface rf_wb_sched_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_stall;
    logic [AW-1:0] chk_ra;
    logic [AW-1:0] chk_rb;
    logic          hazard;
    logic          WrEn;
    logic [AW-1:0] Rw;
    logic [DW-1:0] busW;
    logic          sb_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output iss_valid, iss_rd, chk_ra, chk_rb,
        input  alu_ready, mem_ready, iss_stall, hazard,
        input  WrEn, Rw, busW, sb_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  iss_valid, iss_rd, chk_ra, chk_rb,
        output alu_ready, mem_ready, iss_stall, hazard,
        output WrEn, Rw, busW, sb_err
    );
endinterface

// File: rtl/rf_wb_sched.sv
// Write-back scheduler and RAW hazard scoreboard for the 32x32 register file.
// Round-robin shares the single rf write port between ALU and MEM; a 2-bit
// counter per register tracks outstanding writes so decode can detect hazards.
module rf_wb_sched #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic          Clk,
    input logic          Rst_n,
    rf_wb_sched_if.slave bus
);
    localparam int NREG = 2 ** AW;

    // Round-robin pointer: 1 means ALU wins the next contested cycle.
    logic          prio_alu_r;
    logic          alu_gnt_s;
    logic          mem_gnt_s;

    // Registered rf write port.
    logic          wr_en_r;
    logic [AW-1:0] rw_r;
    logic [DW-1:0] bus_w_r;

    // Scoreboard state.
    logic [1:0]    cnt_r     [NREG];
    logic [1:0]    cnt_nxt_s [NREG];
    logic          err_s;
    logic          sb_err_r;
    logic          iss_stall_s;
    logic          iss_inc_s;
    logic          hazard_s;

    // Non-zero register address test (r0 is never tracked or written).
    function automatic logic reg_nz(input logic [AW-1:0] addr);
        return (addr != {AW{1'b0}});
    endfunction

    // Round-robin grant: a lone requester wins, a contested cycle goes to the favoured side.
    always_comb begin
        alu_gnt_s = 1'b0;
        mem_gnt_s = 1'b0;
        if (bus.alu_valid && bus.mem_valid) begin
            if (prio_alu_r) begin
                alu_gnt_s = 1'b1;
            end else begin
                mem_gnt_s = 1'b1;
            end
        end else if (bus.alu_valid) begin
            alu_gnt_s = 1'b1;
        end else if (bus.mem_valid) begin
            mem_gnt_s = 1'b1;
        end else begin
            alu_gnt_s = 1'b0;
            mem_gnt_s = 1'b0;
        end
    end

    // Pointer moves only on an actual grant, away from the side just served.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prio_alu_r <= 1'b1;
        end else if (alu_gnt_s) begin
            prio_alu_r <= 1'b0;
        end else if (mem_gnt_s) begin
            prio_alu_r <= 1'b1;
        end else begin
            prio_alu_r <= prio_alu_r;
        end
    end

    // Capture the granted transfer into the rf write port; r0 transfers never raise WrEn.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_en_r <= 1'b0;
            rw_r    <= {AW{1'b0}};
            bus_w_r <= {DW{1'b0}};
        end else if (alu_gnt_s) begin
            wr_en_r <= reg_nz(bus.alu_rd);
            rw_r    <= bus.alu_rd;
            bus_w_r <= bus.alu_data;
        end else if (mem_gnt_s) begin
            wr_en_r <= reg_nz(bus.mem_rd);
            rw_r    <= bus.mem_rd;
            bus_w_r <= bus.mem_data;
        end else begin
            wr_en_r <= 1'b0;
            rw_r    <= rw_r;
            bus_w_r <= bus_w_r;
        end
    end

    // Stall a reservation whose counter is saturated, unless a commit to it frees a slot this edge.
    always_comb begin
        iss_stall_s = 1'b0;
        if (bus.iss_valid && reg_nz(bus.iss_rd) && (cnt_r[bus.iss_rd] == 2'd3) &&
            !(wr_en_r && (rw_r == bus.iss_rd))) begin
            iss_stall_s = 1'b1;
        end else begin
            iss_stall_s = 1'b0;
        end
        iss_inc_s = bus.iss_valid && reg_nz(bus.iss_rd) && !iss_stall_s;
    end

    // Next counter values: reservations increment, the write sitting on the rf port decrements.
    always_comb begin
        logic inc_v;
        logic dec_v;
        inc_v = 1'b0;
        dec_v = 1'b0;
        err_s = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            inc_v = iss_inc_s && (bus.iss_rd == AW'(i));
            dec_v = wr_en_r && (rw_r == AW'(i));
            if (AW'(i) == {AW{1'b0}}) begin
                cnt_nxt_s[i] = 2'd0;
            end else if (inc_v && !dec_v) begin
                cnt_nxt_s[i] = cnt_r[i] + 2'd1;
            end else if (dec_v && !inc_v) begin
                if (cnt_r[i] == 2'd0) begin
                    err_s = 1'b1;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] - 2'd1;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Scoreboard counters and the sticky unreserved-commit flag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= 2'd0;
            end
            sb_err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            sb_err_r <= sb_err_r | err_s;
        end
    end

    // Hazard when either decoded source has an outstanding write.
    always_comb begin
        hazard_s = 1'b0;
        if ((reg_nz(bus.chk_ra) && (cnt_r[bus.chk_ra] != 2'd0)) ||
            (reg_nz(bus.chk_rb) && (cnt_r[bus.chk_rb] != 2'd0))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign bus.alu_ready = alu_gnt_s;
    assign bus.mem_ready = mem_gnt_s;
    assign bus.iss_stall = iss_stall_s;
    assign bus.hazard    = hazard_s;
    assign bus.WrEn      = wr_en_r;
    assign bus.Rw        = rw_r;
    assign bus.busW      = bus_w_r;
    assign bus.sb_err    = sb_err_r;
endmodule
